// File: rtl/mem_bus_initiator_if.sv
// Core-side request/response handshake and the virtual memory bus driven by mem_bus_initiator.
// The master modport is the initiator's view; slave is the view of the core and the responder.
interface mem_bus_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic [1:0]  req_lane;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic [31:0] addressVirt;
  logic [31:0] dataInVirt;
  logic        wEnVirt;
  logic [31:0] dataOutVirt;

  modport master (
    input  req_valid, req_write, req_byte, req_lane, req_addr, req_wdata, dataOutVirt,
    output req_ready, rsp_valid, rsp_rdata, busy, addressVirt, dataInVirt, wEnVirt
  );

  modport slave (
    output req_valid, req_write, req_byte, req_lane, req_addr, req_wdata, dataOutVirt,
    input  req_ready, rsp_valid, rsp_rdata, busy, addressVirt, dataInVirt, wEnVirt
  );
endinterface

// File: rtl/mem_bus_initiator.sv
// Memory bus initiator: single outstanding load/store, waits out READ_LATENCY for read data.
// Optional read-modify-write byte stores are enabled by defining MEM_BYTE_STORE_EN.
module mem_bus_initiator #(
  parameter int unsigned READ_LATENCY = 1
) (
  input logic                 clk,
  input logic                 reset,
  mem_bus_initiator_if.master bus
);

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

`ifdef MEM_BYTE_STORE_EN
  typedef enum logic [1:0] {IDLE, WR, RD, RMW_WR} state_t;
`else
  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
`endif

  state_t     state;
  logic [2:0] cnt;

`ifdef MEM_BYTE_STORE_EN
  logic [1:0] lane;
  logic       rmw;

  // Replace one byte lane of a word read back from memory.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [1:0]  sel,
                                             input logic [7:0]  data);
    logic [31:0] merged;
    merged = word;
    merged[{sel, 3'b000} +: 8] = data;
    return merged;
  endfunction
`else
  logic unused_byte_ctl;
  assign unused_byte_ctl = ^{bus.req_byte, bus.req_lane};
`endif

  // NOTE: every register here is written with <= so all updates take effect together at the
  // edge; a blocking = would let later statements see the new value within the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.req_ready   <= 1'b1;
      bus.busy        <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.addressVirt <= '0;
      bus.dataInVirt  <= '0;
      bus.wEnVirt     <= 1'b0;
`ifdef MEM_BYTE_STORE_EN
      lane            <= '0;
      rmw             <= 1'b0;
`endif
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.addressVirt <= bus.req_addr;
            bus.dataInVirt  <= bus.req_wdata;
            cnt             <= '0;
            bus.req_ready   <= 1'b0;
            bus.busy        <= 1'b1;
`ifdef MEM_BYTE_STORE_EN
            lane <= bus.req_lane;
            rmw  <= bus.req_write && bus.req_byte;
            if (bus.req_write && !bus.req_byte) begin
`else
            if (bus.req_write) begin
`endif
              state       <= WR;
              bus.wEnVirt <= 1'b1;
            end else begin
              state <= RD;
            end
          end
        end

        RD: begin
          if (cnt == LAT) begin
`ifdef MEM_BYTE_STORE_EN
            if (rmw) begin
              // Read half of a byte store: write back the merged word next cycle.
              bus.dataInVirt <= merge_lane(bus.dataOutVirt, lane, bus.dataInVirt[7:0]);
              bus.wEnVirt    <= 1'b1;
              state          <= RMW_WR;
            end else begin
              bus.rsp_rdata <= bus.dataOutVirt;
              bus.rsp_valid <= 1'b1;
              bus.req_ready <= 1'b1;
              bus.busy      <= 1'b0;
              state         <= IDLE;
            end
`else
            bus.rsp_rdata <= bus.dataOutVirt;
            bus.rsp_valid <= 1'b1;
            bus.req_ready <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
`endif
          end else begin
            cnt <= cnt + 3'd1;
          end
        end

`ifdef MEM_BYTE_STORE_EN
        WR, RMW_WR: begin
`else
        WR: begin
`endif
          bus.wEnVirt   <= 1'b0;
          bus.rsp_valid <= 1'b1;
          bus.rsp_rdata <= '0;
          bus.req_ready <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end

        default: begin
          bus.wEnVirt   <= 1'b0;
          bus.req_ready <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Bench for mem_bus_initiator: two instances (READ_LATENCY 1 and 3) each on a BRAM model,
// directed vector table, hand sequences and a randomized phase against a word-memory model.
module tb_mem_bus_initiator;

`ifdef MEM_BYTE_STORE_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic mem_clr;
  always #5 clk = ~clk;

  mem_bus_initiator_if b1();
  mem_bus_initiator_if b3();

  mem_bus_initiator #(.READ_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  mem_bus_initiator #(.READ_LATENCY(3)) dut3 (.clk(clk), .reset(reset), .bus(b3));

  // Shared request drivers; sel steers req_valid to one instance.
  logic        sel, v_valid, v_write, v_byte;
  logic [1:0]  v_lane;
  logic [31:0] v_addr, v_wdata;

  assign b1.req_valid = v_valid && !sel;
  assign b3.req_valid = v_valid && sel;
  assign b1.req_write = v_write;
  assign b3.req_write = v_write;
  assign b1.req_byte  = v_byte;
  assign b3.req_byte  = v_byte;
  assign b1.req_lane  = v_lane;
  assign b3.req_lane  = v_lane;
  assign b1.req_addr  = v_addr;
  assign b3.req_addr  = v_addr;
  assign b1.req_wdata = v_wdata;
  assign b3.req_wdata = v_wdata;

  // Synchronous BRAM responders: sample address each edge, data READ_LATENCY edges later.
  logic [31:0] ram1 [64];
  logic [31:0] ram3 [64];
  logic [31:0] p3a, p3b;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) begin
        ram1[i] <= '0;
        ram3[i] <= '0;
      end
    end else begin
      if (b1.wEnVirt) ram1[b1.addressVirt[5:0]] <= b1.dataInVirt;
      if (b3.wEnVirt) ram3[b3.addressVirt[5:0]] <= b3.dataInVirt;
    end
    b1.dataOutVirt <= ram1[b1.addressVirt[5:0]];
    p3a            <= ram3[b3.addressVirt[5:0]];
    p3b            <= p3a;
    b3.dataOutVirt <= p3b;
  end

  // Acceptance and write-enable cycle counters.
  int acc1 = 0, acc3 = 0, wen1 = 0, wen3 = 0;
  always @(posedge clk) begin
    if (!reset && b1.req_valid && b1.req_ready) acc1 <= acc1 + 1;
    if (!reset && b3.req_valid && b3.req_ready) acc3 <= acc3 + 1;
    if (b1.wEnVirt) wen1 <= wen1 + 1;
    if (b3.wEnVirt) wen3 <= wen3 + 1;
  end

  wire        cur_ready = sel ? b3.req_ready   : b1.req_ready;
  wire        cur_rsp   = sel ? b3.rsp_valid   : b1.rsp_valid;
  wire [31:0] cur_rdata = sel ? b3.rsp_rdata   : b1.rsp_rdata;
  wire [31:0] cur_addr  = sel ? b3.addressVirt : b1.addressVirt;
  wire [31:0] cur_din   = sel ? b3.dataInVirt  : b1.dataInVirt;
  wire        cur_wen   = sel ? b3.wEnVirt     : b1.wEnVirt;

  function automatic int cur_acc();
    return sel ? acc3 : acc1;
  endfunction

  function automatic int cur_wcnt();
    return sel ? wen3 : wen1;
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  // Reference model: one word memory per instance, transactions as whole operations.
  logic [31:0] mm1 [64];
  logic [31:0] mm3 [64];

  task automatic model(input bit s, input logic w, input logic bt, input logic [1:0] ln,
                       input logic [5:0] a, input logic [31:0] wd,
                       output logic [31:0] rdata, output int lat, output int wen,
                       output logic [31:0] wword);
    logic [31:0] old, mask;
    int          l;
    l     = s ? 3 : 1;
    old   = s ? mm3[a] : mm1[a];
    rdata = '0;
    wen   = 1;
    if (!w) begin
      rdata = old;
      lat   = l + 1;
      wen   = 0;
      wword = old;
    end else if (bt && BYTE_EN) begin
      mask  = 32'hFF << (8 * ln);
      wword = (old & ~mask) | ((wd & 32'hFF) << (8 * ln));
      lat   = l + 2;
    end else begin
      wword = wd;
      lat   = 1;
    end
    if (w) begin
      if (s) mm3[a] = wword;
      else   mm1[a] = wword;
    end
  endtask

  // Issue one request (called at a negedge) and follow it to its response.
  task automatic txn(input bit s, input logic w, input logic bt, input logic [1:0] ln,
                     input logic [31:0] a, input logic [31:0] wd, input bit hold,
                     input logic [31:0] exp_rdata, input int exp_lat, input int exp_wen,
                     input logic [31:0] exp_wdata, input string nm, output int waited);
    int acc0, wen0, k;
    bit bus_ok;
    sel = s; v_write = w; v_byte = bt; v_lane = ln; v_addr = a; v_wdata = wd;
    v_valid = 1'b1;
    #1;
    waited = 0;
    while (!cur_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!cur_ready) begin
      check({nm, " accept timeout"}, 32'd0, 32'd1);
      v_valid = 1'b0;
      return;
    end
    acc0 = cur_acc();
    wen0 = cur_wcnt();
    @(negedge clk);
    if (!hold) v_valid = 1'b0;
    k      = 0;
    bus_ok = 1'b1;
    while (k < 20) begin
      if (cur_addr !== a) bus_ok = 1'b0;
      if (cur_wen && cur_din !== exp_wdata) bus_ok = 1'b0;
      if (cur_rsp) break;
      @(negedge clk);
      k++;
    end
    check({nm, " latency"}, 32'(k), 32'(exp_lat));
    check({nm, " rdata"}, cur_rdata, exp_rdata);
    check({nm, " wen cycles"}, 32'(cur_wcnt() - wen0), 32'(exp_wen));
    check({nm, " acceptances"}, 32'(cur_acc() - acc0), 32'd1);
    check({nm, " bus addr/data"}, {31'd0, bus_ok}, 32'd1);
    check({nm, " ready with rsp"}, {31'd0, cur_ready}, 32'd1);
  endtask

  typedef struct {
    bit          s;
    logic        w;
    logic        bt;
    logic [1:0]  ln;
    logic [31:0] a;
    logic [31:0] wd;
    bit          hold;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  initial begin : main
    logic [31:0] m_rdata, m_wword, ra, rwd;
    int          m_lat, m_wen, waited, gaps;
    bit          rsp_seen, rs, rw, rb, rh;
    logic [1:0]  rl;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'h10, 32'hCAFEF00D, 1'b0, 32'h0, 1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h10, 32'h0, 1'b1, 32'hCAFEF00D, 4};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h20, 32'h11223344, 1'b0, 32'h0, 1};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 2'd2, 32'h20, 32'h000000AB, 1'b0, 32'h0, BYTE_EN ? 3 : 1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h20, 32'h0, 1'b0,
                BYTE_EN ? 32'h11AB3344 : 32'h000000AB, 2};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 2'd0, 32'h20, 32'hFFFFFF5A, 1'b1, 32'h0, BYTE_EN ? 5 : 1};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h20, 32'h0, 1'b0,
                BYTE_EN ? 32'h0000005A : 32'hFFFFFF5A, 4};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h3F, 32'h0, 1'b0, 32'h0, 2};

    reset = 1'b1; mem_clr = 1'b1;
    sel = 1'b0; v_valid = 1'b0; v_write = 1'b0; v_byte = 1'b0; v_lane = '0;
    v_addr = '0; v_wdata = '0;
    for (int i = 0; i < 64; i++) begin
      mm1[i] = '0;
      mm3[i] = '0;
    end
    repeat (3) @(negedge clk);

    check("reset req_ready",   {31'd0, b1.req_ready}, 32'd1);
    check("reset busy",        {31'd0, b1.busy},      32'd0);
    check("reset rsp_valid",   {31'd0, b1.rsp_valid}, 32'd0);
    check("reset rsp_rdata",   b1.rsp_rdata,          32'd0);
    check("reset addressVirt", b1.addressVirt,        32'd0);
    check("reset dataInVirt",  b1.dataInVirt,         32'd0);
    check("reset wEnVirt",     {31'd0, b1.wEnVirt},   32'd0);
    check("reset L3 req_ready", {31'd0, b3.req_ready}, 32'd1);
    check("reset L3 wEnVirt",   {31'd0, b3.wEnVirt},   32'd0);

    reset = 1'b0; mem_clr = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      model(vecs[i].s, vecs[i].w, vecs[i].bt, vecs[i].ln, vecs[i].a[5:0], vecs[i].wd,
            m_rdata, m_lat, m_wen, m_wword);
      txn(vecs[i].s, vecs[i].w, vecs[i].bt, vecs[i].ln, vecs[i].a, vecs[i].wd, vecs[i].hold,
          vecs[i].exp_rdata, vecs[i].exp_lat, m_wen, m_wword, $sformatf("vec%0d", i), waited);
      v_valid = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d single rsp pulse", i), {31'd0, cur_rsp}, 32'd0);
    end

    // Back-to-back store, load, store with req_valid held high throughout.
    model(1'b0, 1'b1, 1'b0, 2'd0, 6'h30, 32'h0BADF00D, m_rdata, m_lat, m_wen, m_wword);
    txn(1'b0, 1'b1, 1'b0, 2'd0, 32'h30, 32'h0BADF00D, 1'b1, m_rdata, m_lat, m_wen, m_wword,
        "b2b st0", waited);
    model(1'b0, 1'b0, 1'b0, 2'd0, 6'h30, 32'h0, m_rdata, m_lat, m_wen, m_wword);
    txn(1'b0, 1'b0, 1'b0, 2'd0, 32'h30, 32'h0, 1'b1, m_rdata, m_lat, m_wen, m_wword,
        "b2b ld", waited);
    check("b2b ld accepted in rsp cycle", 32'(waited), 32'd0);
    model(1'b0, 1'b1, 1'b0, 2'd0, 6'h31, 32'h12345678, m_rdata, m_lat, m_wen, m_wword);
    txn(1'b0, 1'b1, 1'b0, 2'd0, 32'h31, 32'h12345678, 1'b1, m_rdata, m_lat, m_wen, m_wword,
        "b2b st1", waited);
    check("b2b st1 accepted in rsp cycle", 32'(waited), 32'd0);
    v_valid = 1'b0;
    @(negedge clk);

    // Reset one cycle after accepting a load: transaction dropped silently.
    sel = 1'b0; v_write = 1'b0; v_byte = 1'b0; v_addr = 32'h10; v_valid = 1'b1;
    @(negedge clk);
    check("rst-in-RD accepted", {31'd0, b1.req_ready}, 32'd0);
    v_valid = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    check("rst-in-RD rsp_valid",   {31'd0, b1.rsp_valid}, 32'd0);
    check("rst-in-RD req_ready",   {31'd0, b1.req_ready}, 32'd1);
    check("rst-in-RD busy",        {31'd0, b1.busy},      32'd0);
    check("rst-in-RD addressVirt", b1.addressVirt,        32'd0);
    reset    = 1'b0;
    rsp_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (b1.rsp_valid) rsp_seen = 1'b1;
    end
    check("rst-in-RD no stray rsp", {31'd0, rsp_seen}, 32'd0);
    model(1'b0, 1'b0, 1'b0, 2'd0, 6'h10, 32'h0, m_rdata, m_lat, m_wen, m_wword);
    txn(1'b0, 1'b0, 1'b0, 2'd0, 32'h10, 32'h0, 1'b0, m_rdata, m_lat, m_wen, m_wword,
        "post-reset ld", waited);
    v_valid = 1'b0;
    @(negedge clk);

    // Randomized traffic on both instances against the memory model.
    for (int i = 0; i < 60; i++) begin
      rs  = 1'($urandom_range(0, 1));
      rw  = 1'($urandom_range(0, 1));
      rb  = 1'($urandom_range(0, 1));
      rh  = 1'($urandom_range(0, 1));
      rl  = 2'($urandom_range(0, 3));
      ra  = ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 7));
      rwd = $urandom;
      model(rs, rw, rb, rl, ra[5:0], rwd, m_rdata, m_lat, m_wen, m_wword);
      txn(rs, rw, rb, rl, ra, rwd, rh, m_rdata, m_lat, m_wen, m_wword,
          $sformatf("rnd%0d", i), waited);
      gaps = $urandom_range(0, 2);
      if (gaps != 0 || rh == 1'b0) begin
        v_valid = 1'b0;
        repeat (gaps) @(negedge clk);
      end
    end
    v_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_bus_initiator.md
# mem_bus_initiator

Bus master for the CPU-side memory bus: accepts load/store requests from the core over a valid/ready handshake, drives `addressVirt`/`dataInVirt`/`wEnVirt` toward the memory/peripheral responder, and waits out the synchronous BRAM read latency. It then captures `dataOutVirt` and returns a one-cycle response. It sits between the core's load/store stage and the memory responder, and it is the only driver of the virtual bus.

## Interface

- `READ_LATENCY`, 1, clock edges between the responder sampling an address and `dataOutVirt` becoming valid. Legal range 1–7.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  initiator can accept a request this cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_byte`  in  1  byte store. Only used with `MEM_BYTE_STORE_EN`.
- `req_lane`  in  2  byte lane for a byte store. Lane k is bits 8k+7:8k.
- `req_addr`  in  32  word address, passed to the bus unchanged.
- `req_wdata`  in  32  store data. A byte store uses bits 7:0.
- `rsp_valid`  out  1  one-cycle pulse; transaction complete.
- `rsp_rdata`  out  32  load data, valid while `rsp_valid`=1. Reads 0 for stores.
- `busy`  out  1  transaction in flight (= !`req_ready`).
- `addressVirt`  out  32  bus address.
- `dataInVirt`  out  32  bus write data.
- `wEnVirt`  out  1  bus write enable.
- `dataOutVirt`  in  32  bus read data from the responder.

## Operation

- All outputs are registered. Reset values:
  - `req_ready`=1
  - `rsp_valid`=0, `rsp_rdata`=0, `busy`=0
  - `addressVirt`=0, `dataInVirt`=0, `wEnVirt`=0
- States: IDLE, WR, RD, RMW_WR (RMW_WR exists only with the macro).
- IDLE:
  - A request is accepted on an edge where `req_valid` && `req_ready`.
  - On acceptance, latch addr/wdata/lane into `addressVirt`/`dataInVirt`/lane register.
  - Go to WR if this is a word store (or a byte store without the macro). Go to RD otherwise.
- WR:
  - `wEnVirt`=1 for exactly one cycle.
  - Next edge: `wEnVirt`←0, `rsp_valid`←1, `rsp_rdata`←0, go to IDLE with `req_ready`←1.
- RD:
  - `wEnVirt`=0. Latency counter loads 0 on entry and increments each edge.
  - On the edge where the counter equals `READ_LATENCY`, capture `dataOutVirt`.
  - For a load: on that edge, `rsp_rdata`←`dataOutVirt`, `rsp_valid`←1, go to IDLE.
  - For a byte store: on that edge, `dataInVirt`←the captured word with the lane replaced by `req_wdata[7:0]`, `wEnVirt`←1, go to RMW_WR.
- RMW_WR:
  - Behaves identically to WR, then returns to IDLE with `rsp_valid`←1.
- `addressVirt` is held constant from acceptance until return to IDLE. It keeps its last value in IDLE.
- `wEnVirt` is never high outside WR/RMW_WR.
- Requests presented while `req_ready`=0 are ignored, not queued.
- No response backpressure: the consumer must take `rsp_valid` the cycle it appears.
- `reset` asserted on any edge, in any state:
  - Go to IDLE and apply the reset values above.
  - The in-flight transaction is dropped with no `rsp_valid`.
  - A write already issued to the bus is not undone.

## Timing

- Accept edge = E0. `req_ready` falls after E0.
- Word store: `wEnVirt`=1 in the cycle E0→E1. `rsp_valid`=1 in cycle E1→E2. Next acceptance is possible at E2 (2-cycle throughput).
- Load: address valid from after E0. Data is captured at E(READ_LATENCY+1). `rsp_valid` is high in the following cycle. Accept-to-response = READ_LATENCY+1 edges (2 for the default).
- Byte store (macro): read phase as for a load. `wEnVirt`=1 in cycle E(L+1)→E(L+2). `rsp_valid` is high in cycle E(L+2)→E(L+3), where L=`READ_LATENCY`.
- A request may be accepted in the same cycle `rsp_valid` is high. This gives back-to-back operation with no idle bubble beyond the above.

## Configuration

- `MEM_BYTE_STORE_EN` defined:
  - `req_byte`=1 with `req_write`=1 performs a read-modify-write of the lane selected by `req_lane`.
  - Bus traffic is 1 read plus 1 write.
- Not defined:
  - `req_byte` and `req_lane` are ignored, and every store is a full-word WR.
  - RMW_WR and the merge logic are absent.

## Test plan

- Reset, then word store addr 0x10, data 0xDEADBEEF:
  - `wEnVirt` is high exactly 1 cycle with `addressVirt`=0x10, `dataInVirt`=0xDEADBEEF.
  - `rsp_valid` pulses at E1.
- Load addr 0x10 after that store, with a BRAM model at `READ_LATENCY`=1:
  - `rsp_rdata`=0xDEADBEEF with `rsp_valid` at E2.
  - `wEnVirt` stays 0 throughout.
- `READ_LATENCY`=3: load completes at E4. `req_valid` held high during the busy cycles produces no extra acceptance.
- Macro on, memory word 0x11223344 at 0x20: byte store lane 2, data 0xAB → memory holds 0x11AB3344 and `rsp_valid` pulses once. With the macro off, the same request writes 0x000000AB.
- Reset asserted in RD, one cycle after acceptance: no `rsp_valid`, `req_ready`=1 on the next cycle. A subsequent load completes normally.
- Back-to-back store, load, store with `req_valid` held high: each is accepted in the cycle its predecessor's `rsp_valid` is high, and there are no lost or duplicated `wEnVirt` pulses.
